// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Number of beats needed to send one word.
    function automatic int beat_count(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    // Beat counter width: clog2 of the beat count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Lowest word bit carried on lane 0 for a given beat; lane j carries
    // that bit plus j in both orders, so higher lanes always hold higher bits.
    function automatic int beat_lsb(input int data_w, input int lanes,
                                    input int beat, input bit msb_first);
        if (msb_first)
            return data_w - (beat + 1) * lanes;
        else
            return beat * lanes;
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-word holding buffer in front of the shift stage. It also produces
// s_ready from a flop and selects between the buffered word and a bypass
// of the incoming word when the shift stage is free.
module ser_hold_buf
    import serializer_pkg::*;
#(
    parameter int DATA_W = 60
) (
    input  logic              clk_25G,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              load_free,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data
);

    logic              buf_full;
    logic [DATA_W-1:0] buf_q;
    logic              accept;
    logic              full_nxt;

    assign accept   = s_valid && s_ready;
    // The buffered word always goes before a freshly accepted one.
    assign ld_valid = buf_full || accept;
    assign ld_data  = buf_full ? buf_q : s_data;
    // On a free edge the buffer drains (refilled only if a word also
    // arrives); otherwise it fills when a word is accepted.
    assign full_nxt = load_free ? (buf_full && accept) : (buf_full || accept);

    // Full flag and ready flop; ready is precomputed so it never depends on s_valid.
    always_ff @(posedge clk_25G or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            s_ready  <= 1'b1;
        end else begin
            buf_full <= full_nxt;
            s_ready  <= !full_nxt;
        end
    end

    // Capture an accepted word unless it bypasses straight into the shift stage.
    always_ff @(posedge clk_25G) begin
        if (accept && (buf_full || !load_free))
            buf_q <= s_data;
    end

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial converter: words arrive over valid/ready and leave
// LANES bits per clock, with a one-word buffer for gapless streaming.
module par_serializer
    import serializer_pkg::*;
#(
    parameter int   DATA_W    = 60,
    parameter int   LANES     = 1,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk_25G,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [LANES-1:0]  data_serial,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              underflow
);

    localparam int N     = beat_count(DATA_W, LANES);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    ser_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [LANES-1:0]  beat;
    logic              free;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;

    // The shift stage can take a new word when idle or on its last beat.
    assign free = (state == ST_IDLE) || (cnt == CNT_LAST);
    assign beat = LANES'(shreg >> beat_lsb(DATA_W, LANES, int'(cnt), MSB_FIRST));

    ser_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk_25G   (clk_25G),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .load_free (free),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data)
    );

    // Load the shift stage on a free edge when a word is available.
    always_ff @(posedge clk_25G) begin
        if (free && ld_valid)
            shreg <= ld_data;
    end

    // FSM, beat counter and registered serial outputs.
    always_ff @(posedge clk_25G or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            data_serial  <= {LANES{IDLE_BIT}};
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (free) begin
                state <= ld_valid ? ST_SHIFT : ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == ST_SHIFT) begin
                data_serial  <= beat;
                serial_valid <= 1'b1;
                frame_start  <= (cnt == '0);
            end else begin
                data_serial  <= {LANES{IDLE_BIT}};
                serial_valid <= 1'b0;
                frame_start  <= 1'b0;
            end

            // Idle now while the last registered beat was valid means the
            // previous free edge found no data: pulse together with the drop
            // of serial_valid.
            underflow <= (state == ST_IDLE) && serial_valid;
        end
    end

endmodule

// File: tb/tb_par_serializer.sv
// Randomized scoreboard bench for par_serializer: a default instance
// (60 bits, 1 lane, LSB first, idle 0) and a wide one (64 bits, 4 lanes,
// MSB first, idle 1).
module tb_par_serializer;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n1;
    logic        sv0, sv1;
    logic [59:0] sd0;
    logic [63:0] sd1;
    logic        rdy0, rdy1;
    logic [0:0]  ds0;
    logic [3:0]  ds1;
    logic        vld0, vld1, fs0, fs1, uf0, uf1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [4:0] exp_q [2][$];   // {frame_start, beat}
    int acc_cyc [2];
    int fs_cyc  [2];
    int uf_cyc  [2];
    int vbeats  [2];
    int ufs     [2];
    int drops   [2];
    int rdy_low [2];
    bit prev_v  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    par_serializer #(.DATA_W(60), .LANES(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
        .clk_25G(clk), .rst_n(rst_n0), .s_valid(sv0), .s_ready(rdy0), .s_data(sd0),
        .data_serial(ds0), .serial_valid(vld0), .frame_start(fs0), .underflow(uf0));

    par_serializer #(.DATA_W(64), .LANES(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut1 (
        .clk_25G(clk), .rst_n(rst_n1), .s_valid(sv1), .s_ready(rdy1), .s_data(sd1),
        .data_serial(ds1), .serial_valid(vld1), .frame_start(fs1), .underflow(uf1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: expand a word into its beats from the bit-order rule.
    task automatic push_word(input int d, input logic [63:0] w);
        int dw, l, n;
        bit msb;
        logic [3:0] b;
        logic f;
        dw  = (d == 0) ? 60 : 64;
        l   = (d == 0) ? 1 : 4;
        msb = (d == 1);
        n   = dw / l;
        for (int i = 0; i < n; i++) begin
            b = '0;
            for (int j = 0; j < l; j++)
                b[j] = msb ? w[dw - 1 - i*l - (l-1) + j] : w[i*l + j];
            f = (i == 0);
            exp_q[d].push_back({f, b});
        end
    endtask

    // Monitor: every cycle, compare outputs against the scoreboard and idle rules.
    task automatic mon(input int d, input logic rstn, input logic v, input logic [3:0] ds,
                       input logic fs, input logic uf, input logic rdy, input logic [3:0] idle);
        logic [4:0] e;
        if (!rstn) begin
            prev_v[d] = 1'b0;
            return;
        end
        if (!rdy) rdy_low[d]++;
        check($sformatf("underflow%0d", d), {63'd0, uf}, {63'd0, prev_v[d] && !v});
        if (uf) begin
            ufs[d]++;
            uf_cyc[d] = cyc;
        end
        if (prev_v[d] && !v) drops[d]++;
        if (v) begin
            vbeats[d]++;
            if (fs) fs_cyc[d] = cyc;
            if (exp_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat%0d: got beat %0h, expected no payload", d, ds);
            end else begin
                e = exp_q[d].pop_front();
                check($sformatf("beat%0d", d), {59'd0, fs, ds}, {59'd0, e});
            end
        end else begin
            check($sformatf("idle_data%0d", d), {60'd0, ds}, {60'd0, idle});
            check($sformatf("idle_frame%0d", d), {63'd0, fs}, 64'd0);
        end
        prev_v[d] = v;
    endtask

    always @(negedge clk) begin
        mon(0, rst_n0, vld0, {3'b000, ds0}, fs0, uf0, rdy0, 4'h0);
        mon(1, rst_n1, vld1, ds1, fs1, uf1, rdy1, 4'hF);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; the model is updated on acceptance.
    task automatic send_word(input int d, input logic [63:0] w, input bit hold);
        int t;
        logic rdy;
        t = 0;
        if (d == 0) begin sv0 = 1'b1; sd0 = w[59:0]; end
        else        begin sv1 = 1'b1; sd1 = w; end
        forever begin
            rdy = (d == 0) ? rdy0 : rdy1;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout%0d: got no s_ready, expected acceptance", d);
                #1;
                if (d == 0) sv0 = 1'b0; else sv1 = 1'b0;
                return;
            end
        end
        push_word(d, w);
        #1;
        acc_cyc[d] = cyc;
        if (!hold) begin
            if (d == 0) sv0 = 1'b0; else sv1 = 1'b0;
        end
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (exp_q[d].size() != 0) begin
            wait_cycles(1);
            t++;
            if (t > 3000) begin
                checks++;
                errors++;
                $display("FAIL drain%0d: got %0d beats pending, expected 0", d, exp_q[d].size());
                break;
            end
        end
        wait_cycles(4);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int b0, u0, d0, r0, rel, g;
        logic [63:0] w;
        for (int i = 0; i < 2; i++) begin
            acc_cyc[i] = 0; fs_cyc[i] = 0; uf_cyc[i] = 0; vbeats[i] = 0;
            ufs[i] = 0; drops[i] = 0; rdy_low[i] = 0; prev_v[i] = 1'b0;
        end
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        sv0 = 1'b0; sv1 = 1'b0; sd0 = '0; sd1 = '0;

        // Reset state
        wait_cycles(3);
        check("rst_valid0", {63'd0, vld0}, 64'd0);
        check("rst_valid1", {63'd0, vld1}, 64'd0);
        check("rst_data0",  {63'd0, ds0}, 64'd0);
        check("rst_data1",  {60'd0, ds1}, 64'hF);
        check("rst_ready0", {63'd0, rdy0}, 64'd1);
        check("rst_ready1", {63'd0, rdy1}, 64'd1);
        check("rst_uf0",    {63'd0, uf0}, 64'd0);
        check("rst_fs1",    {63'd0, fs1}, 64'd0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        wait_cycles(2);

        // Single word with defaults: latency and underflow timing
        u0 = ufs[0];
        send_word(0, 64'h1, 1'b0);
        drain(0);
        check("single_fs_latency", fs_cyc[0], acc_cyc[0] + 1);
        check("single_uf_latency", uf_cyc[0], acc_cyc[0] + 61);
        check("single_uf_count",   ufs[0] - u0, 1);

        // Back-to-back: 8 words with s_valid held high
        b0 = vbeats[0]; u0 = ufs[0]; d0 = drops[0]; r0 = rdy_low[0];
        for (int i = 0; i < 8; i++)
            send_word(0, rnd64(), i != 7);
        drain(0);
        check("b2b_beats",     vbeats[0] - b0, 480);
        check("b2b_drops",     drops[0] - d0, 1);
        check("b2b_uf",        ufs[0] - u0, 1);
        check("b2b_ready_low", {63'd0, (rdy_low[0] - r0) > 0}, 64'd1);

        // Source stall of 100 cycles between two words
        u0 = ufs[0];
        send_word(0, rnd64(), 1'b0);
        wait_cycles(100);
        check("stall_uf_gap", ufs[0] - u0, 1);
        send_word(0, rnd64(), 1'b0);
        drain(0);
        check("stall_fs_latency", fs_cyc[0], acc_cyc[0] + 1);
        check("stall_uf_total",   ufs[0] - u0, 2);

        // Wide config, MSB first
        u0 = ufs[1];
        send_word(1, 64'hFEDC_BA98_7654_3210, 1'b0);
        drain(1);
        check("wide_fs_latency", fs_cyc[1], acc_cyc[1] + 1);
        check("wide_uf_latency", uf_cyc[1], acc_cyc[1] + 17);
        check("wide_uf_count",   ufs[1] - u0, 1);
        b0 = vbeats[1]; d0 = drops[1];
        for (int i = 0; i < 6; i++)
            send_word(1, rnd64(), i != 5);
        drain(1);
        check("wide_b2b_beats", vbeats[1] - b0, 96);
        check("wide_b2b_drops", drops[1] - d0, 1);

        // Reset mid-word with a word waiting in the buffer
        send_word(0, rnd64(), 1'b1);
        send_word(0, rnd64(), 1'b0);
        wait_cycles(20);
        rst_n0 = 1'b0;
        #1;
        exp_q[0].delete();
        check("midrst_valid", {63'd0, vld0}, 64'd0);
        check("midrst_data",  {63'd0, ds0}, 64'd0);
        check("midrst_fs",    {63'd0, fs0}, 64'd0);
        check("midrst_uf",    {63'd0, uf0}, 64'd0);
        check("midrst_ready", {63'd0, rdy0}, 64'd1);
        wait_cycles(3);
        rst_n0 = 1'b1;
        rel = cyc;
        send_word(0, 64'h0123456789ABCDE, 1'b0);
        check("postrst_accept", acc_cyc[0], rel + 1);
        drain(0);
        check("postrst_fs_latency", fs_cyc[0], acc_cyc[0] + 1);

        // Randomized traffic with random gaps on both instances
        for (int i = 0; i < 20; i++) begin
            w = rnd64();
            send_word(0, w, 1'b1);
            g = $urandom_range(0, 70);
            if (g != 0) begin
                sv0 = 1'b0;
                wait_cycles(g);
            end
        end
        sv0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            w = rnd64();
            send_word(1, w, 1'b1);
            g = $urandom_range(0, 20);
            if (g != 0) begin
                sv1 = 1'b0;
                wait_cycles(g);
            end
        end
        sv1 = 1'b0;
        drain(0);
        drain(1);
        check("final_q0_empty", exp_q[0].size(), 0);
        check("final_q1_empty", exp_q[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
